// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t        : controller states (IDLE, DIVIDE, FIXUP)
//   DEFAULT_WIDTH  : default operand/result width
//   MAX_WIDTH      : widest operand the helper function handles
//   DIV0_QUOTIENT  : quotient reported on divide by zero (all ones)
//   abs_val        : conditional two's-complement negation, used both to take
//                    magnitudes and to re-apply signs
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2
    } state_t;

    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // Callers zero-extend into MAX_WIDTH and truncate the result back; since
    // negation is modular the low bits are correct for any narrower width.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] v,
                                                     input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider.
//   master : drives start/dividend/divisor, observes busy/done/results
//   slave  : the divider side
// Handshake: start is sampled on a rising edge only while busy=0; that edge
// accepts the operands and raises busy. start while busy=1 is ignored. done
// is a one-cycle pulse in the first cycle the results are valid; busy is
// already low then, so a new start may be presented in that same cycle.
// quotient/remainder/div_by_zero hold until the next result is written.
interface seq_divider_if #(parameter int WIDTH = div_pkg::DEFAULT_WIDTH);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (combinational).
//   rem_in  : partial remainder, always < dvs
//   quo_in  : shifting dividend/quotient register
//   dvs     : divisor magnitude (non-zero)
//   rem_out : next partial remainder
//   quo_out : next quotient register, new quotient bit in bit 0
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // {R,Q} << 1: the dividend bit leaving Q enters the bottom of R.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    // Since rem_in < dvs, shifted < 2*dvs: a non-negative trial fits in WIDTH
    // bits and a negative one always has bit WIDTH set.
    assign trial   = shifted - {1'b0, dvs};

    assign rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider serving DIV/REM beside the multiplier.
// One quotient bit per clock; done WIDTH+1 edges after the accept edge
// (two edges including the accept edge on divide by zero).
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : seq_divider_if.slave (start/operands in, busy/done/results out)
//   state_dbg : current controller state
// Build option: SEQ_DIVIDER_SIGNED_EN selects two's-complement operands with
// sign fixup; without it operands are unsigned. Latency is the same in both.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus,
    output state_t        state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_acc;     // partial remainder R (raw dividend when div0)
    logic [WIDTH-1:0] quo_acc;     // dividend magnitude shifting out, Q shifting in
    logic [WIDTH-1:0] dvs_mag;
    logic             div0;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] dvd_in_mag, dvs_in_mag;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             done_r, dz_r;
    logic             dvs_zero;

    assign dvs_zero = (bus.divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sgn_dvd, sgn_dvs;
    logic neg_quo, neg_rem;

    assign sgn_dvd    = bus.dividend[WIDTH-1];
    assign sgn_dvs    = bus.divisor[WIDTH-1];
    assign dvd_in_mag = WIDTH'(abs_val(MAX_WIDTH'(bus.dividend), sgn_dvd));
    assign dvs_in_mag = WIDTH'(abs_val(MAX_WIDTH'(bus.divisor), sgn_dvs));
    // MIN / -1 needs no special case: |MIN| = 2^(WIDTH-1) divides to itself,
    // the signs agree, so the quotient bits read back as MIN.
    assign quo_fix    = WIDTH'(abs_val(MAX_WIDTH'(quo_acc), neg_quo));
    assign rem_fix    = WIDTH'(abs_val(MAX_WIDTH'(rem_acc), neg_rem));
`else
    assign dvd_in_mag = bus.dividend;
    assign dvs_in_mag = bus.divisor;
    assign quo_fix    = quo_acc;
    assign rem_fix    = rem_acc;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_acc),
        .quo_in  (quo_acc),
        .dvs     (dvs_mag),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = dvs_zero ? FIXUP : DIVIDE;
            DIVIDE:  if (cnt == CNT_W'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dvs_mag     <= '0;
            div0        <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            dz_r        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt     <= CNT_W'(WIDTH);
                        dvs_mag <= dvs_in_mag;
                        quo_acc <= dvd_in_mag;
                        // On divide by zero R carries the raw dividend straight
                        // to FIXUP, where it becomes the remainder.
                        rem_acc <= dvs_zero ? bus.dividend : '0;
                        div0    <= dvs_zero;
                        dz_r    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo <= sgn_dvd ^ sgn_dvs;
                        neg_rem <= sgn_dvd;
`endif
                    end
                end
                DIVIDE: begin
                    rem_acc <= rem_step;
                    quo_acc <= quo_step;
                    cnt     <= cnt - CNT_W'(1);
                end
                FIXUP: begin
                    done_r      <= 1'b1;
                    dz_r        <= div0;
                    quotient_r  <= div0 ? DIV0_QUOTIENT[WIDTH-1:0] : quo_fix;
                    remainder_r <= div0 ? rem_acc : rem_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dz_r;
    assign state_dbg       = state;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed cases followed by random operands,
// checked against an arithmetic reference model through an expected queue.
// Honours SEQ_DIVIDER_SIGNED_EN the same way as the design.
module tb_seq_divider;
    import div_pkg::*;

    parameter int WIDTH = 32;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL1    = '1;

    logic   clk = 1'b0;
    logic   rst;
    state_t state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [2*WIDTH:0] exp_q[$];
    logic [2*WIDTH:0] last_exp;

    seq_divider_if #(.WIDTH(WIDTH)) bus();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model: {div_by_zero, quotient, remainder}.
    function automatic logic [2*WIDTH:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] q, r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic signed [WIDTH-1:0] sa, sb;
        sa = a;
        sb = b;
`endif
        if (b == '0) return {1'b1, ALL1, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (a == MIN_VAL && b == ALL1) begin
            q = MIN_VAL;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    // ---------------- drivers ----------------
    // Called at a negedge with the divider idle (or in its done cycle).
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back(model(a, b));
        lat = (b == '0) ? 1 : WIDTH + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for done, counting edges after the accept edge. With poke set, a
    // 50/5 start is presented midway while the divider is busy.
    task automatic wait_result(input int lat, input bit poke);
        int n        = 0;
        int busy_cnt = 0;
        int poke_at  = (lat > 10) ? 9 : lat / 2;
        bit seen     = 1'b0;
        while (n < lat + 4 && !seen) begin
            if (bus.busy) busy_cnt++;
            if (poke && n == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = WIDTH'(50);
                bus.divisor  = WIDTH'(5);
            end
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 1);
        check("latency", n, lat);
        check("busy_cycles", busy_cnt, lat);
        check("busy_at_done", bus.busy, 0);
        last_exp = exp_q.pop_front();
        check("quotient", bus.quotient, last_exp[2*WIDTH-1:WIDTH]);
        check("remainder", bus.remainder, last_exp[WIDTH-1:0]);
        check("div_by_zero", bus.div_by_zero, last_exp[2*WIDTH]);
    endtask

    // One idle cycle after done: the pulse must end and results must hold.
    task automatic idle_step();
        @(negedge clk);
        check("done_pulse_end", bus.done, 0);
        check("quotient_held", bus.quotient, last_exp[2*WIDTH-1:WIDTH]);
        check("remainder_held", bus.remainder, last_exp[WIDTH-1:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int done_cnt;
        logic [WIDTH-1:0] a, b;
        int sel;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_div_by_zero", bus.div_by_zero, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Basic divide.
        issue(WIDTH'(100), WIDTH'(7), lat);
        wait_result(lat, 1'b0);
        idle_step();

        // Negative dividend.
        issue(WIDTH'(-7), WIDTH'(2), lat);
        wait_result(lat, 1'b0);
        idle_step();

        // Divide by zero.
        issue(WIDTH'(32'h12345678), '0, lat);
        wait_result(lat, 1'b0);
        idle_step();

        // MIN / -1.
        issue(MIN_VAL, ALL1, lat);
        wait_result(lat, 1'b0);
        idle_step();

        // Start while busy is ignored; then back-to-back start in done cycle.
        issue(WIDTH'(100), WIDTH'(7), lat);
        wait_result(lat, 1'b1);
        issue(WIDTH'(50), WIDTH'(5), lat);
        wait_result(lat, 1'b0);
        idle_step();

        // Reset mid-operation.
        issue(WIDTH'(100), WIDTH'(7), lat);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_div_by_zero", bus.div_by_zero, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("no_done_after_rst", done_cnt, 0);
        issue(WIDTH'(9), WIDTH'(3), lat);
        wait_result(lat, 1'b0);
        idle_step();

        // Random operands, occasional busy pokes and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            a   = WIDTH'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = '0;
            else if (sel < 3)  b = WIDTH'($urandom_range(1, 15));
            else if (sel == 7) b = ALL1;
            else               b = WIDTH'($urandom);
            issue(a, b, lat);
            wait_result(lat, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
